// File: rtl/fetch_decode_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_pkg
// Shared definitions for the CPU front end: the op_mne instruction mnemonic
// enum used by fetch and execute, the fetch FSM state enum, opcode constants
// and the pure opcode-to-mnemonic mapping function.
// -----------------------------------------------------------------------------
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    LW   = 3'd0,
    SW   = 3'd1,
    SET  = 3'd2,
    BNE  = 3'd3,
    PAR  = 3'd4,
    ADD  = 3'd5,
    XOR  = 3'd6,
    LSOR = 3'd7
  } op_mne_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Opcode 001 has no mnemonic of its own; it stops the program.
  localparam logic [2:0] kHALT = 3'b001;

  // Loads and stores share opcode 000 and are told apart by this bit.
  localparam int kLSW_SW_BIT = 5;

  // Maps a raw instruction onto its mnemonic. HALT has no mnemonic and
  // falls through to LW; callers never register it.
  function automatic op_mne_e opToMne(input logic [8:0] instr);
    op_mne_e op;
    unique case (instr[8:6])
      3'b000:  op = instr[kLSW_SW_BIT] ? SW : LW;
      3'b010:  op = SET;
      3'b011:  op = BNE;
      3'b100:  op = PAR;
      3'b101:  op = ADD;
      3'b110:  op = XOR;
      3'b111:  op = LSOR;
      default: op = LW;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_if
// Bundles the front-end signals: control from the sequencer (start), hazard
// and redirect inputs from execute (stall, br_taken, br_target), the
// instruction ROM port (imem_addr/imem_data) and the decode register outputs
// (dec_valid, dec_op, dec_instr, dec_pc, illegal, done).
//   master : the fetch_decode stage
//   slave  : the surrounding core (execute stage, ROM, sequencer)
// -----------------------------------------------------------------------------
interface fetch_decode_if
  import fetch_decode_pkg::*;
#(
  parameter int PC_W = 10
);

  logic            start;
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic            dec_valid;
  op_mne_e         dec_op;
  logic [8:0]      dec_instr;
  logic [PC_W-1:0] dec_pc;
  logic            illegal;
  logic            done;

  modport master (
    input  start, stall, br_taken, br_target, imem_data,
    output imem_addr, dec_valid, dec_op, dec_instr, dec_pc, illegal, done
  );

  modport slave (
    output start, stall, br_taken, br_target, imem_data,
    input  imem_addr, dec_valid, dec_op, dec_instr, dec_pc, illegal, done
  );

endinterface

// File: rtl/fetch_decode_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational decode of one 9-bit instruction.
//   instr  in  9  raw instruction from the ROM
//   op     out    op_mne mnemonic (don't-care when isHalt)
//   isHalt out 1  instruction is HALT (opcode 001)
// -----------------------------------------------------------------------------
module instr_decode
  import fetch_decode_pkg::*;
(
  input  logic [8:0] instr,
  output op_mne_e    op,
  output logic       isHalt
);

  assign op     = opToMne(instr);
  assign isHalt = (instr[8:6] == kHALT);

endmodule

// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
// Front-end stage of the CPU. Owns the program counter, fetches one 9-bit
// instruction per cycle from a combinational ROM and registers it with its
// decoded mnemonic for the execute stage. Sequenced by an IDLE/RUN/DONE FSM;
// honours stalls and taken-branch redirects from execute, and stops on HALT.
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   bus    master modport of fetch_decode_if:
//     start, stall, br_taken, br_target, imem_data      (inputs)
//     imem_addr, dec_valid, dec_op, dec_instr, dec_pc,
//     illegal, done                                     (outputs)
// -----------------------------------------------------------------------------
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int          PC_W     = 10,
  parameter int unsigned START_PC = 0
) (
  input  logic           Clk,
  input  logic           Reset,
  fetch_decode_if.master bus
);

  localparam logic [PC_W-1:0] kStartPc = PC_W'(START_PC);

  fetch_state_e state, stateNext;

  // Fetch stage (p0): program counter
  logic [PC_W-1:0] pc_p0, pcNext_p0;

  // Decode register (p1)
  logic            decValid_p1, decValidNext_p1;
  op_mne_e         decOp_p1;
  logic [8:0]      decInstr_p1;
  logic [PC_W-1:0] decPc_p1;
  logic            decLoad;

  logic            done, doneNext;

  op_mne_e         fetchOp;
  logic            fetchIsHalt;

  instr_decode uDecode (
    .instr  (bus.imem_data),
    .op     (fetchOp),
    .isHalt (fetchIsHalt)
  );

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // FSM: next-state logic. A redirect outranks both stall and HALT, so a
  // HALT on the wrong path never stops the machine.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (bus.start) stateNext = RUN;
      RUN:  if (!bus.br_taken && !bus.stall && fetchIsHalt) stateNext = DONE;
      DONE: if (bus.start) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  // FSM: output logic (next values for PC, decode register and done)
  always_comb begin
    pcNext_p0       = pc_p0;
    decValidNext_p1 = decValid_p1;
    decLoad         = 1'b0;
    doneNext        = done;
    unique case (state)
      IDLE: begin
        decValidNext_p1 = 1'b0;
        if (bus.start) pcNext_p0 = kStartPc;
      end
      RUN: begin
        if (bus.br_taken) begin
          // Squash whatever was fetched on the wrong path.
          pcNext_p0       = bus.br_target;
          decValidNext_p1 = 1'b0;
        end else if (bus.stall) begin
          // Hold everything.
        end else if (fetchIsHalt) begin
          // PC parks on the HALT address.
          decValidNext_p1 = 1'b0;
          doneNext        = 1'b1;
        end else begin
          decLoad         = 1'b1;
          decValidNext_p1 = 1'b1;
          pcNext_p0       = pc_p0 + PC_W'(1);  // wraps modulo 2^PC_W
        end
      end
      DONE: begin
        decValidNext_p1 = 1'b0;
        if (bus.start) begin
          pcNext_p0 = kStartPc;
          doneNext  = 1'b0;
        end
      end
      default: begin
        decValidNext_p1 = 1'b0;
      end
    endcase
  end

  // Fetch stage (p0) -> decode register (p1) boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0       <= kStartPc;
      decValid_p1 <= 1'b0;
      decOp_p1    <= LW;
      decInstr_p1 <= '0;
      decPc_p1    <= '0;
      done        <= 1'b0;
    end else begin
      pc_p0       <= pcNext_p0;
      decValid_p1 <= decValidNext_p1;
      done        <= doneNext;
      if (decLoad) begin
        decOp_p1    <= fetchOp;
        decInstr_p1 <= bus.imem_data;
        decPc_p1    <= pc_p0;
      end
    end
  end

  assign bus.imem_addr = pc_p0;
  assign bus.dec_valid = decValid_p1;
  assign bus.dec_op    = decOp_p1;
  assign bus.dec_instr = decInstr_p1;
  assign bus.dec_pc    = decPc_p1;
  assign bus.illegal   = 1'b0;   // every opcode is legal; reserved
  assign bus.done      = done;

endmodule
